// File: rtl/atm_pkg.sv
// Shared types for the multi-account ATM controller: session states,
// operation codes, error codes and the bundle of one-cycle response pulses.
package atm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_PIN = 2'd1,
    ST_WAIT_BIO = 2'd2,
    ST_WAIT_OP  = 2'd3
  } state_e;

  localparam logic [1:0] OP_WITHDRAW   = 2'b00;
  localparam logic [1:0] OP_CHANGE_PIN = 2'b01;
  localparam logic [1:0] OP_QUERY      = 2'b10;
  localparam logic [1:0] OP_EJECT      = 2'b11;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_LOCKED       = 3'd1,
    ERR_BAD_PIN      = 3'd2,
    ERR_BIO_FAIL     = 3'd3,
    ERR_ZERO_AMT     = 3'd4,
    ERR_OVER_LIMIT   = 3'd5,
    ERR_INSUFFICIENT = 3'd6,
    ERR_SAME_PIN     = 3'd7
  } err_e;

  // One-cycle response pulses, registered together in the top module.
  typedef struct packed {
    logic txn_success;
    logic txn_error;
    logic pin_change_success;
    logic timeout_error;
    logic balance_valid;
  } pulse_t;

  localparam pulse_t PULSE_NONE = 5'b00000;

endpackage

// File: rtl/atm_multi_account_ctrl_timer.sv
// Session inactivity timer. Counts cycles while a session is open and flags
// expiry when TIMEOUT_CYCLES-1 cycles have passed since the last reload.
module atm_inactivity_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic reload,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on reload or outside a session, saturate at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = CNT_ZERO;
    end else if (!run) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/atm_multi_account_ctrl.sv
// Multi-account ATM session controller: card -> PIN -> biometric -> operations,
// with per-account PIN, balance, failed-attempt counter and lock flag.
module atm_multi_account_ctrl
  import atm_pkg::*;
#(
  parameter int               NUM_ACCOUNTS   = 4,
  parameter int               PIN_W          = 4,
  parameter int               AMT_W          = 8,
  parameter int               BAL_W          = 16,
  parameter int               MAX_ATTEMPTS   = 3,
  parameter int               TIMEOUT_CYCLES = 16,
  parameter int               TXN_LIMIT      = 100,
  parameter logic [PIN_W-1:0] DEFAULT_PIN    = 4'b1010,
  parameter int               INIT_BALANCE   = 500,
  localparam int              ACC_W          = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             card_valid,
  input  logic [ACC_W-1:0] card_id,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin_input,
  input  logic             bio_valid,
  input  logic             bio_ok,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [AMT_W-1:0] amount_input,
  input  logic [PIN_W-1:0] new_pin,
  input  logic             admin_unlock,
  input  logic [ACC_W-1:0] admin_id,
  output logic             busy,
  output logic             transaction_success,
  output logic             transaction_error,
  output logic [2:0]       error_code,
  output logic             pin_change_success,
  output logic             account_locked,
  output logic             timeout_error,
  output logic [BAL_W-1:0] balance_out,
  output logic             balance_valid
);

  localparam int               FAIL_W    = (MAX_ATTEMPTS > 1) ? $clog2(MAX_ATTEMPTS + 1) : 1;
  localparam logic [FAIL_W-1:0] FAIL_ZERO = {FAIL_W{1'b0}};
  localparam logic [FAIL_W-1:0] FAIL_ONE  = FAIL_W'(1'b1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_ATTEMPTS - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_ATTEMPTS);
  localparam logic [AMT_W-1:0]  LIMIT_AMT = AMT_W'(TXN_LIMIT);
  localparam logic [BAL_W-1:0]  INIT_BAL  = BAL_W'(INIT_BALANCE);
  localparam logic [BAL_W-1:0]  BAL_ZERO  = {BAL_W{1'b0}};
  localparam logic [ACC_W-1:0]  ACC_ZERO  = {ACC_W{1'b0}};

  // Per-account storage.
  logic [PIN_W-1:0]  pin_q  [NUM_ACCOUNTS];
  logic [PIN_W-1:0]  pin_d  [NUM_ACCOUNTS];
  logic [BAL_W-1:0]  bal_q  [NUM_ACCOUNTS];
  logic [BAL_W-1:0]  bal_d  [NUM_ACCOUNTS];
  logic [FAIL_W-1:0] fail_q [NUM_ACCOUNTS];
  logic [FAIL_W-1:0] fail_d [NUM_ACCOUNTS];
  logic              lock_q [NUM_ACCOUNTS];
  logic              lock_d [NUM_ACCOUNTS];

  // Session state and registered outputs.
  state_e            state_q, state_d;
  logic [ACC_W-1:0]  cur_id_q, cur_id_d;
  pulse_t            pulse_q, pulse_d;
  err_e              err_q, err_d;
  logic [BAL_W-1:0]  bal_out_q, bal_out_d;
  logic              busy_q, busy_d;
  logic              locked_q, locked_d;

  err_e              wd_err_s;
  logic              reload_s;
  logic              run_s;
  logic              expired_s;

  // Withdrawal screening in priority order; ERR_NONE means the debit may proceed.
  function automatic err_e check_withdraw(input logic [AMT_W-1:0] amt,
                                          input logic [BAL_W-1:0] bal);
    err_e res;
    if (amt == {AMT_W{1'b0}}) begin
      res = ERR_ZERO_AMT;
    end else if (amt > LIMIT_AMT) begin
      res = ERR_OVER_LIMIT;
    end else if (BAL_W'(amt) > bal) begin
      res = ERR_INSUFFICIENT;
    end else begin
      res = ERR_NONE;
    end
    return res;
  endfunction

  assign run_s = (state_q != ST_IDLE);

  atm_inactivity_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run_s),
    .reload  (reload_s),
    .expired (expired_s)
  );

  // Next-state, account updates and response pulses; a consumed strobe beats timer expiry.
  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    pin_d     = pin_q;
    bal_d     = bal_q;
    fail_d    = fail_q;
    lock_d    = lock_q;
    pulse_d   = PULSE_NONE;
    err_d     = ERR_NONE;
    bal_out_d = bal_out_q;
    reload_s  = 1'b0;
    wd_err_s  = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (card_valid) begin
          reload_s = 1'b1;
          cur_id_d = card_id;
          if (lock_q[card_id]) begin
            pulse_d.txn_error = 1'b1;
            err_d             = ERR_LOCKED;
          end else begin
            state_d = ST_WAIT_PIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_PIN: begin
        if (pin_valid) begin
          reload_s = 1'b1;
          if (pin_input == pin_q[cur_id_q]) begin
            fail_d[cur_id_q] = FAIL_ZERO;
            state_d          = ST_WAIT_BIO;
          end else if (fail_q[cur_id_q] >= FAIL_LAST) begin
            fail_d[cur_id_q]  = FAIL_MAX;
            lock_d[cur_id_q]  = 1'b1;
            pulse_d.txn_error = 1'b1;
            err_d             = ERR_LOCKED;
            state_d           = ST_IDLE;
          end else begin
            fail_d[cur_id_q]  = fail_q[cur_id_q] + FAIL_ONE;
            pulse_d.txn_error = 1'b1;
            err_d             = ERR_BAD_PIN;
          end
        end else if (expired_s) begin
          pulse_d.timeout_error = 1'b1;
          state_d               = ST_IDLE;
        end else begin
          state_d = ST_WAIT_PIN;
        end
      end

      ST_WAIT_BIO: begin
        if (bio_valid) begin
          reload_s = 1'b1;
          if (bio_ok) begin
            state_d = ST_WAIT_OP;
          end else begin
            pulse_d.txn_error = 1'b1;
            err_d             = ERR_BIO_FAIL;
            state_d           = ST_IDLE;
          end
        end else if (expired_s) begin
          pulse_d.timeout_error = 1'b1;
          state_d               = ST_IDLE;
        end else begin
          state_d = ST_WAIT_BIO;
        end
      end

      ST_WAIT_OP: begin
        if (op_valid) begin
          reload_s = 1'b1;
          case (op_code)
            OP_WITHDRAW: begin
              wd_err_s = check_withdraw(amount_input, bal_q[cur_id_q]);
              if (wd_err_s != ERR_NONE) begin
                pulse_d.txn_error = 1'b1;
                err_d             = wd_err_s;
              end else begin
                bal_d[cur_id_q]     = bal_q[cur_id_q] - BAL_W'(amount_input);
                pulse_d.txn_success = 1'b1;
              end
            end
            OP_CHANGE_PIN: begin
              if (new_pin == pin_q[cur_id_q]) begin
                pulse_d.txn_error = 1'b1;
                err_d             = ERR_SAME_PIN;
              end else begin
                pin_d[cur_id_q]            = new_pin;
                pulse_d.pin_change_success = 1'b1;
              end
            end
            OP_QUERY: begin
              bal_out_d             = bal_q[cur_id_q];
              pulse_d.balance_valid = 1'b1;
            end
            OP_EJECT: begin
              state_d = ST_IDLE;
            end
            default: begin
              state_d = ST_WAIT_OP;
            end
          endcase
        end else if (expired_s) begin
          pulse_d.timeout_error = 1'b1;
          state_d               = ST_IDLE;
        end else begin
          state_d = ST_WAIT_OP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Administrative unlock is applied last so it wins over a same-cycle lock.
    if (admin_unlock) begin
      lock_d[admin_id] = 1'b0;
      fail_d[admin_id] = FAIL_ZERO;
    end else begin
      lock_d[admin_id] = lock_d[admin_id];
    end

    busy_d   = (state_d != ST_IDLE);
    locked_d = lock_d[cur_id_d];
  end

  // State, account storage and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        pin_q[i]  <= DEFAULT_PIN;
        bal_q[i]  <= INIT_BAL;
        fail_q[i] <= FAIL_ZERO;
        lock_q[i] <= 1'b0;
      end
      state_q   <= ST_IDLE;
      cur_id_q  <= ACC_ZERO;
      pulse_q   <= PULSE_NONE;
      err_q     <= ERR_NONE;
      bal_out_q <= BAL_ZERO;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      pin_q     <= pin_d;
      bal_q     <= bal_d;
      fail_q    <= fail_d;
      lock_q    <= lock_d;
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      pulse_q   <= pulse_d;
      err_q     <= err_d;
      bal_out_q <= bal_out_d;
      busy_q    <= busy_d;
      locked_q  <= locked_d;
    end
  end

  assign busy                = busy_q;
  assign transaction_success = pulse_q.txn_success;
  assign transaction_error   = pulse_q.txn_error;
  assign error_code          = err_q;
  assign pin_change_success  = pulse_q.pin_change_success;
  assign account_locked      = locked_q;
  assign timeout_error       = pulse_q.timeout_error;
  assign balance_out         = bal_out_q;
  assign balance_valid       = pulse_q.balance_valid;

endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// Self-checking bench for atm_multi_account_ctrl: directed vector table,
// hand-written timeout/reset sequences and random traffic against a
// transaction-level reference model.
module tb_atm_multi_account_ctrl;

  localparam int N_ACC  = 4;
  localparam int TMO    = 16;
  localparam int LIMIT  = 100;
  localparam int MAXATT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        card_valid, pin_valid, bio_valid, bio_ok, op_valid, admin_unlock;
  logic [1:0]  card_id, admin_id, op_code;
  logic [3:0]  pin_input, new_pin;
  logic [7:0]  amount_input;
  logic        busy, transaction_success, transaction_error, pin_change_success;
  logic        account_locked, timeout_error, balance_valid;
  logic [2:0]  error_code;
  logic [15:0] balance_out;

  always #5 clk = ~clk;

  atm_multi_account_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .card_valid(card_valid), .card_id(card_id),
    .pin_valid(pin_valid), .pin_input(pin_input),
    .bio_valid(bio_valid), .bio_ok(bio_ok),
    .op_valid(op_valid), .op_code(op_code),
    .amount_input(amount_input), .new_pin(new_pin),
    .admin_unlock(admin_unlock), .admin_id(admin_id),
    .busy(busy), .transaction_success(transaction_success),
    .transaction_error(transaction_error), .error_code(error_code),
    .pin_change_success(pin_change_success), .account_locked(account_locked),
    .timeout_error(timeout_error), .balance_out(balance_out),
    .balance_valid(balance_valid)
  );

  typedef struct { bit cv; int cid; bit pv; int pin; bit bv; bit bok;
                   bit ov; int op; int amt; int npin; bit au; int aid; } stim_t;
  typedef struct { int err; bit succ; bit pc; bit busy; bit lock; bit bv; int bal; } tex_t;
  typedef struct { stim_t st; tex_t xp; } vec_t;
  typedef struct { bit succ; bit err; int code; bit pc; bit lock; bit tmo;
                   bit busy; bit bv; int bal; } mex_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tab[$];

  // Reference model: session phase 0 none, 1 awaiting PIN, 2 awaiting biometric, 3 serving ops.
  int m_phase, m_acct, m_quiet;
  int m_pin[N_ACC], m_bal[N_ACC], m_fail[N_ACC];
  bit m_lock[N_ACC];

  function automatic void model_reset();
    m_phase = 0; m_acct = 0; m_quiet = 0;
    for (int i = 0; i < N_ACC; i++) begin
      m_pin[i] = 10; m_bal[i] = 500; m_fail[i] = 0; m_lock[i] = 1'b0;
    end
  endfunction

  function automatic mex_t model_eval(stim_t s);
    mex_t e = '{default: 0};
    bit used = 1'b0;
    int start = m_phase;
    case (m_phase)
      0: if (s.cv) begin
           used = 1'b1; m_acct = s.cid;
           if (m_lock[m_acct]) begin e.err = 1'b1; e.code = 1; end
           else m_phase = 1;
         end
      1: if (s.pv) begin
           used = 1'b1;
           if (s.pin == m_pin[m_acct]) begin m_fail[m_acct] = 0; m_phase = 2; end
           else begin
             m_fail[m_acct] += 1;
             if (m_fail[m_acct] >= MAXATT) begin
               m_lock[m_acct] = 1'b1; e.err = 1'b1; e.code = 1; m_phase = 0;
             end else begin
               e.err = 1'b1; e.code = 2;
             end
           end
         end
      2: if (s.bv) begin
           used = 1'b1;
           if (s.bok) m_phase = 3;
           else begin e.err = 1'b1; e.code = 3; m_phase = 0; end
         end
      3: if (s.ov) begin
           used = 1'b1;
           case (s.op)
             0: if (s.amt == 0) begin e.err = 1'b1; e.code = 4; end
                else if (s.amt > LIMIT) begin e.err = 1'b1; e.code = 5; end
                else if (s.amt > m_bal[m_acct]) begin e.err = 1'b1; e.code = 6; end
                else begin m_bal[m_acct] -= s.amt; e.succ = 1'b1; end
             1: if (s.npin == m_pin[m_acct]) begin e.err = 1'b1; e.code = 7; end
                else begin m_pin[m_acct] = s.npin; e.pc = 1'b1; end
             2: begin e.bv = 1'b1; e.bal = m_bal[m_acct]; end
             default: m_phase = 0;
           endcase
         end
      default: m_phase = 0;
    endcase
    if (used) m_quiet = 0;
    else if (start != 0) begin
      if (m_quiet == TMO - 1) begin e.tmo = 1'b1; m_phase = 0; end
      else m_quiet += 1;
    end
    if (s.au) begin m_lock[s.aid] = 1'b0; m_fail[s.aid] = 0; end
    e.lock = m_lock[m_acct];
    e.busy = (m_phase != 0);
    return e;
  endfunction

  function automatic stim_t idle_in();
    stim_t r = '{default: 0};
    return r;
  endfunction
  function automatic stim_t card_in(int id);
    stim_t r = idle_in(); r.cv = 1'b1; r.cid = id; return r;
  endfunction
  function automatic stim_t pin_in(int p);
    stim_t r = idle_in(); r.pv = 1'b1; r.pin = p; return r;
  endfunction
  function automatic stim_t bio_in(bit ok);
    stim_t r = idle_in(); r.bv = 1'b1; r.bok = ok; return r;
  endfunction
  function automatic stim_t op_in(int op, int amt, int np);
    stim_t r = idle_in(); r.ov = 1'b1; r.op = op; r.amt = amt; r.npin = np; return r;
  endfunction
  function automatic stim_t admin_in(int id);
    stim_t r = idle_in(); r.au = 1'b1; r.aid = id; return r;
  endfunction
  function automatic tex_t ex(int err, bit succ, bit pc, bit bsy, bit lck, bit bv, int bal);
    tex_t t; t.err = err; t.succ = succ; t.pc = pc; t.busy = bsy; t.lock = lck; t.bv = bv; t.bal = bal;
    return t;
  endfunction
  function automatic void add(stim_t s, tex_t x);
    vec_t v; v.st = s; v.xp = x; tab.push_back(v);
  endfunction

  task automatic apply(stim_t s);
    card_valid = s.cv;   card_id   = 2'(s.cid);
    pin_valid  = s.pv;   pin_input = 4'(s.pin);
    bio_valid  = s.bv;   bio_ok    = s.bok;
    op_valid   = s.ov;   op_code   = 2'(s.op);
    amount_input = 8'(s.amt); new_pin = 4'(s.npin);
    admin_unlock = s.au; admin_id  = 2'(s.aid);
  endtask

  task automatic check_model(mex_t e, string tag);
    bit bad;
    n_cmp++;
    bad = (transaction_success !== e.succ) || (transaction_error !== e.err) ||
          (e.err && (int'(error_code) != e.code)) || (pin_change_success !== e.pc) ||
          (account_locked !== e.lock) || (timeout_error !== e.tmo) || (busy !== e.busy) ||
          (balance_valid !== e.bv) || (e.bv && (int'(balance_out) != e.bal));
    if (bad) begin
      n_bad++;
      $display("FAIL %s @%0t: got succ=%0b err=%0b code=%0d pc=%0b lock=%0b tmo=%0b busy=%0b bv=%0b bal=%0d; expected succ=%0b err=%0b code=%0d pc=%0b lock=%0b tmo=%0b busy=%0b bv=%0b bal=%0d",
               tag, $time, transaction_success, transaction_error, error_code, pin_change_success,
               account_locked, timeout_error, busy, balance_valid, balance_out,
               e.succ, e.err, e.code, e.pc, e.lock, e.tmo, e.busy, e.bv, e.bal);
    end
  endtask

  task automatic step(stim_t s, string tag);
    mex_t e;
    apply(s);
    e = model_eval(s);
    @(posedge clk); #1;
    check_model(e, tag);
  endtask

  task automatic expect_int(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_tab(int row, tex_t x);
    int act_err = transaction_error ? int'(error_code) : 0;
    n_cmp++;
    if (act_err != x.err || transaction_success !== x.succ || pin_change_success !== x.pc ||
        busy !== x.busy || account_locked !== x.lock || balance_valid !== x.bv ||
        (x.bv && int'(balance_out) != x.bal)) begin
      n_bad++;
      $display("FAIL table[%0d]: got err=%0d succ=%0b pc=%0b busy=%0b lock=%0b bv=%0b bal=%0d; expected err=%0d succ=%0b pc=%0b busy=%0b lock=%0b bv=%0b bal=%0d",
               row, act_err, transaction_success, pin_change_success, busy, account_locked,
               balance_valid, balance_out, x.err, x.succ, x.pc, x.busy, x.lock, x.bv, x.bal);
    end
  endtask

  task automatic login(int acct, int p);
    step(card_in(acct), "login_card");
    step(pin_in(p), "login_pin");
    step(bio_in(1'b1), "login_bio");
  endtask

  initial begin
    stim_t r;
    reset_n = 1'b0;
    apply(idle_in());
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    expect_int("reset_outputs",
               int'({busy, transaction_success, transaction_error, error_code, pin_change_success,
                     account_locked, timeout_error, balance_out, balance_valid}), 0);
    reset_n = 1'b1;

    // Directed vectors: ex(err, succ, pin_chg, busy, locked, bal_valid, balance)
    add(card_in(0),      ex(0, 0, 0, 1, 0, 0, 0));
    add(pin_in(10),      ex(0, 0, 0, 1, 0, 0, 0));
    add(bio_in(1),       ex(0, 0, 0, 1, 0, 0, 0));
    add(op_in(0, 20, 0), ex(0, 1, 0, 1, 0, 0, 0));
    add(op_in(2, 0, 0),  ex(0, 0, 0, 1, 0, 1, 480));
    add(op_in(0, 0, 0),  ex(4, 0, 0, 1, 0, 0, 0));
    add(op_in(0, 101, 0),ex(5, 0, 0, 1, 0, 0, 0));
    add(op_in(0, 100, 0),ex(0, 1, 0, 1, 0, 0, 0));
    add(op_in(1, 0, 10), ex(7, 0, 0, 1, 0, 0, 0));
    add(op_in(1, 0, 12), ex(0, 0, 1, 1, 0, 0, 0));
    add(op_in(3, 0, 0),  ex(0, 0, 0, 0, 0, 0, 0));
    add(card_in(1),      ex(0, 0, 0, 1, 0, 0, 0));
    add(pin_in(0),       ex(2, 0, 0, 1, 0, 0, 0));
    add(pin_in(0),       ex(2, 0, 0, 1, 0, 0, 0));
    add(pin_in(0),       ex(1, 0, 0, 0, 1, 0, 0));
    add(card_in(1),      ex(1, 0, 0, 0, 1, 0, 0));
    add(admin_in(1),     ex(0, 0, 0, 0, 0, 0, 0));
    add(card_in(1),      ex(0, 0, 0, 1, 0, 0, 0));
    add(pin_in(10),      ex(0, 0, 0, 1, 0, 0, 0));
    add(bio_in(0),       ex(3, 0, 0, 0, 0, 0, 0));
    add(card_in(0),      ex(0, 0, 0, 1, 0, 0, 0));
    add(pin_in(10),      ex(2, 0, 0, 1, 0, 0, 0));
    add(pin_in(12),      ex(0, 0, 0, 1, 0, 0, 0));
    add(bio_in(1),       ex(0, 0, 0, 1, 0, 0, 0));
    add(op_in(3, 0, 0),  ex(0, 0, 0, 0, 0, 0, 0));
    add(card_in(2),      ex(0, 0, 0, 1, 0, 0, 0));
    add(pin_in(10),      ex(0, 0, 0, 1, 0, 0, 0));
    add(bio_in(1),       ex(0, 0, 0, 1, 0, 0, 0));
    add(admin_in(0),     ex(0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) add(op_in(0, 100, 0), ex(0, 1, 0, 1, 0, 0, 0));
    add(op_in(0, 1, 0),  ex(6, 0, 0, 1, 0, 0, 0));
    add(op_in(2, 0, 0),  ex(0, 0, 0, 1, 0, 1, 0));
    add(op_in(3, 0, 0),  ex(0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i].st, "table_model");
      check_tab(i, tab[i].xp);
    end

    // Inactivity: 15 quiet cycles keep the session, the 16th logs out.
    login(3, 10);
    for (int i = 0; i < TMO - 1; i++) step(idle_in(), "quiet");
    expect_int("no_early_timeout", int'(timeout_error), 0);
    step(idle_in(), "expiry");
    expect_int("timeout_pulse", int'(timeout_error), 1);
    expect_int("timeout_busy", int'(busy), 0);

    // A strobe landing in the expiry cycle is served instead of timing out.
    login(3, 10);
    for (int i = 0; i < TMO - 1; i++) step(idle_in(), "quiet2");
    step(op_in(2, 0, 0), "strobe_at_expiry");
    expect_int("expiry_strobe_served", int'(balance_valid), 1);
    expect_int("expiry_strobe_no_tmo", int'(timeout_error), 0);
    expect_int("expiry_strobe_busy", int'(busy), 1);
    step(op_in(3, 0, 0), "eject");

    // Short reset pulse while a withdrawal is presented.
    login(0, m_pin[0]);
    apply(op_in(0, 20, 0));
    #1 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    apply(idle_in());
    model_reset();
    @(posedge clk); #1;
    expect_int("reset_mid_session",
               int'({busy, transaction_success, transaction_error, pin_change_success,
                     timeout_error, balance_valid}), 0);
    login(0, 10);
    expect_int("pin_restored_busy", int'(busy), 1);
    step(op_in(2, 0, 0), "post_reset_query");
    expect_int("balance_restored", int'(balance_out), 500);
    step(op_in(3, 0, 0), "eject");

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      r = idle_in();
      if ((c % 300) < 270) begin
        r.cv   = ($urandom_range(0, 99) < 20);
        r.cid  = $urandom_range(0, N_ACC - 1);
        r.pv   = ($urandom_range(0, 99) < 25);
        r.pin  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : m_pin[m_acct];
        r.bv   = ($urandom_range(0, 99) < 25);
        r.bok  = ($urandom_range(0, 9) != 0);
        r.ov   = ($urandom_range(0, 99) < 25);
        r.op   = $urandom_range(0, 3);
        r.amt  = ($urandom_range(0, 7) == 0) ? ((m_bal[m_acct] > 255) ? 255 : m_bal[m_acct])
                                             : int'($urandom_range(0, 130));
        r.npin = ($urandom_range(0, 3) == 0) ? m_pin[m_acct] : int'($urandom_range(0, 15));
        r.au   = ($urandom_range(0, 49) == 0);
        r.aid  = $urandom_range(0, N_ACC - 1);
      end
      step(r, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/atm_multi_account_ctrl.md
Name: atm_multi_account_ctrl

Overview:
Parametrised successor to the single-account ATM controller. Serves NUM_ACCOUNTS accounts, each with its own PIN, balance, failed-attempt counter and lock flag. Uses valid-qualified inputs for card, PIN, biometric and operation steps, and an internal inactivity timer in place of the external timeout input. Sits between the card/keypad/biometric front-end and the host status interface.

Parameters:
NUM_ACCOUNTS, 4, number of accounts; ACC_W = $clog2(NUM_ACCOUNTS)
PIN_W, 4, PIN width in bits
AMT_W, 8, transaction amount width
BAL_W, 16, balance width
MAX_ATTEMPTS, 3, consecutive wrong PINs before an account locks
TIMEOUT_CYCLES, 16, idle cycles in a session before forced logout
TXN_LIMIT, 100, maximum amount for one withdrawal
DEFAULT_PIN, 4'b1010, PIN of every account after reset
INIT_BALANCE, 500, balance of every account after reset

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
card_valid  in  1  card inserted this cycle
card_id  in  ACC_W  account selected by the card
pin_valid  in  1  PIN entry strobe
pin_input  in  PIN_W  entered PIN
bio_valid  in  1  biometric result strobe
bio_ok  in  1  biometric match
op_valid  in  1  operation strobe
op_code  in  2  00 withdraw, 01 change PIN, 10 balance query, 11 eject
amount_input  in  AMT_W  withdrawal amount
new_pin  in  PIN_W  replacement PIN
admin_unlock  in  1  unlock strobe
admin_id  in  ACC_W  account to unlock
busy  out  1  session active (state != IDLE)
transaction_success  out  1  1-cycle pulse
transaction_error  out  1  1-cycle pulse
error_code  out  3  valid when transaction_error is high
pin_change_success  out  1  1-cycle pulse
account_locked  out  1  level: lock flag of the current or most recently presented account
timeout_error  out  1  1-cycle pulse
balance_out  out  BAL_W  balance of the session account
balance_valid  out  1  1-cycle pulse

Behaviour:
- Reset: every output is 0; state = IDLE. All PINs = DEFAULT_PIN, balances = INIT_BALANCE, fail counters = 0, locks = 0. Reset asserted mid-session aborts the session and emits no pulses.
- All outputs are registered. A response pulse appears exactly 1 cycle after the strobe that caused it.
- Error codes: 1 LOCKED, 2 BAD_PIN, 3 BIO_FAIL, 4 ZERO_AMT, 5 OVER_LIMIT, 6 INSUFFICIENT, 7 SAME_PIN.
- IDLE, on card_valid:
  - Account locked: error LOCKED, account_locked = 1, stay in IDLE.
  - Otherwise: latch card_id and go to WAIT_PIN.
- WAIT_PIN, on pin_valid:
  - PIN matches: clear the fail counter, go to WAIT_BIO.
  - PIN mismatch: increment the fail counter. If the counter reaches MAX_ATTEMPTS, set the lock, emit error LOCKED, go to IDLE. Otherwise emit error BAD_PIN and stay in WAIT_PIN.
  - Fail counters persist across sessions.
- WAIT_BIO, on bio_valid:
  - bio_ok = 1: go to WAIT_OP.
  - bio_ok = 0: error BIO_FAIL, go to IDLE.
- WAIT_OP, on op_valid. The session stays in WAIT_OP until eject or timeout.
  - Withdraw: checks run in this priority order: amount = 0 gives ZERO_AMT; amount > TXN_LIMIT gives OVER_LIMIT; amount > balance gives INSUFFICIENT. Otherwise balance -= amount (zero-extended) and transaction_success pulses. amount = TXN_LIMIT is legal. Balance never wraps.
  - Change PIN: new_pin equal to the current PIN gives SAME_PIN. Otherwise the PIN updates and pin_change_success pulses.
  - Query: balance_out is driven and balance_valid pulses.
  - Eject: go to IDLE with no pulse.
- Strobes not relevant to the current state are ignored. If several strobes arrive in one cycle, only the one the state expects is consumed.
- Inactivity timer:
  - Runs in any state except IDLE.
  - Reloads on every consumed strobe and on entry to a session.
  - When it reaches TIMEOUT_CYCLES-1 with no consumed strobe that cycle: timeout_error pulses, state goes to IDLE, no other pulse is emitted.
  - If a consumed strobe and expiry fall in the same cycle, the strobe wins.
- admin_unlock is accepted in any state. It clears the lock and fail counter of admin_id. If admin_id is the displayed account, account_locked drops on the next cycle. It does not disturb the FSM.
- account_locked updates whenever card_valid latches an id, and also at the moment of locking.

Decomposition:
- Package atm_pkg holds:
  - the state enum (IDLE, WAIT_PIN, WAIT_BIO, WAIT_OP);
  - op_code localparams;
  - the error_code enum;
  - the pulse-output bundle typedef.
- Sub-module atm_inactivity_timer (parameter TIMEOUT_CYCLES; ports clk, reset_n, run, reload, expired).
- Account arrays (PIN, balance, fail counter, lock) live in the top module.

Test Plan:
- Card 0, PIN 1010, bio_ok = 1, withdraw 20 → transaction_success. A following query returns balance_out = 480.
- Card 1, PIN 0000 entered three times → BAD_PIN, BAD_PIN, then LOCKED with account_locked = 1. Card 1 re-inserted → LOCKED immediately. admin_unlock with id 1, then PIN 1010 → reaches WAIT_BIO.
- Withdrawals of 0, 101, 100 → ZERO_AMT, OVER_LIMIT, success. Repeat withdrawals of 100 until balance = 0, then withdraw 1 → INSUFFICIENT.
- Change PIN to 1010 → SAME_PIN. Change to 1100 → success. Eject, re-login with 1010 → BAD_PIN; re-login with 1100 → WAIT_BIO.
- Enter WAIT_OP and hold idle for 16 cycles → timeout_error pulses and busy = 0. op_valid arriving in the expiry cycle → that op is served, no timeout.
- reset_n pulsed low for 3 ns mid-withdraw → no pulses. Balances return to 500 and PINs return to 1010.
